// File: rtl/bip_pkg.sv
// Shared encodings for the BIP1 control unit.
// Covers opcodes, accumulator source select values and FSM states.
package bip_pkg;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/bip_control_if.sv
// Program-memory fetch port plus datapath/data-memory control bus.
// The control unit is the master; memory and datapath sit on the slave side.
interface bip_control_if #(
  parameter int NB_INSTR   = 16,
  parameter int NB_OPERAND = 11,
  parameter int NB_ADDR    = 11
);
  logic [NB_ADDR-1:0]    o_pc_addr;
  logic [NB_INSTR-1:0]   i_instruction;
  logic [1:0]            o_SelA;
  logic                  o_SelB;
  logic                  o_WrAcc;
  logic                  o_op;
  logic [NB_OPERAND-1:0] o_operand;
  logic                  o_WrRam;
  logic                  o_RdRam;

  modport master (
    output o_pc_addr, o_SelA, o_SelB, o_WrAcc, o_op, o_operand, o_WrRam, o_RdRam,
    input  i_instruction
  );

  modport slave (
    input  o_pc_addr, o_SelA, o_SelB, o_WrAcc, o_op, o_operand, o_WrRam, o_RdRam,
    output i_instruction
  );
endinterface

// File: rtl/bip_pc.sv
// Program counter: synchronous reset, increment enable, silent wrap at 2^NB_ADDR.
module bip_pc #(
  parameter int NB_ADDR = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_inc,
  output logic [NB_ADDR-1:0] o_pc
);

  logic [NB_ADDR-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_pc <= '0;
    else if (i_inc)
      r_pc <= r_pc + 1'b1;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/bip_control.sv
// BIP1 control unit: two-cycle fetch/execute FSM, opcode decode, halt and
// saturating executed-instruction counter.
module bip_control
  import bip_pkg::*;
#(
  parameter int NB_INSTR   = 16,
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_ADDR    = 11,
  parameter int NB_COUNT   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  bip_control_if.master       bus,
  output logic                o_halt,
  output logic [NB_COUNT-1:0] o_instr_count
);

  state_t                r_state;
  logic                  r_halt;
  logic [NB_COUNT-1:0]   r_count;
  logic [NB_ADDR-1:0]    w_pc;
  logic                  w_pc_inc;
  logic [NB_OPCODE-1:0]  w_opcode;
  logic [NB_OPERAND-1:0] w_operand;
  logic                  w_is_exec;

  assign w_opcode  = bus.i_instruction[NB_INSTR-1 -: NB_OPCODE];
  assign w_operand = bus.i_instruction[NB_OPERAND-1:0];
  assign w_is_exec = (r_state == ST_EXEC);
  // HLT leaves the PC on its own address so a halted core reports where it stopped.
  assign w_pc_inc  = w_is_exec && (w_opcode != OP_HLT);

  bip_pc #(
    .NB_ADDR (NB_ADDR)
  ) u_pc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_pc_inc),
    .o_pc  (w_pc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_halt  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_start) r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (r_count != '1)
            r_count <= r_count + 1'b1;
          if (w_opcode == OP_HLT) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        default:  r_state <= ST_HALT;
      endcase
    end
  end

  // Controls are combinational from the fetched word and only live in EXEC.
  always_comb begin
    bus.o_SelA    = SELA_MEM;
    bus.o_SelB    = 1'b0;
    bus.o_op      = 1'b0;
    bus.o_WrAcc   = 1'b0;
    bus.o_WrRam   = 1'b0;
    bus.o_RdRam   = 1'b0;
    bus.o_operand = '0;
    if (w_is_exec) begin
      bus.o_operand = w_operand;
      case (w_opcode)
        OP_STO:  bus.o_WrRam = 1'b1;
        OP_LD: begin
          bus.o_SelA  = SELA_MEM;
          bus.o_WrAcc = 1'b1;
          bus.o_RdRam = 1'b1;
        end
        OP_LDI: begin
          bus.o_SelA  = SELA_IMM;
          bus.o_WrAcc = 1'b1;
        end
        OP_ADD: begin
          bus.o_SelA  = SELA_ALU;
          bus.o_WrAcc = 1'b1;
          bus.o_RdRam = 1'b1;
        end
        OP_ADDI: begin
          bus.o_SelA  = SELA_ALU;
          bus.o_SelB  = 1'b1;
          bus.o_WrAcc = 1'b1;
        end
        OP_SUB: begin
          bus.o_SelA  = SELA_ALU;
          bus.o_op    = 1'b1;
          bus.o_WrAcc = 1'b1;
          bus.o_RdRam = 1'b1;
        end
        OP_SUBI: begin
          bus.o_SelA  = SELA_ALU;
          bus.o_SelB  = 1'b1;
          bus.o_op    = 1'b1;
          bus.o_WrAcc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_pc_addr = w_pc;
  assign o_halt        = r_halt;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: program memory model plus an instruction-level
// reference (2 cycles per instruction, table-driven control expectations).
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt;
  logic [15:0] icount;
  logic [15:0] mem [0:2047];
  logic [15:0] instr_q;

  int total = 0;
  int bad   = 0;

  int   m_pc;
  int   m_count;
  logic m_halted;

  bip_control_if bus ();

  bip_control dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .bus           (bus),
    .o_halt        (halt),
    .o_instr_count (icount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_q <= mem[bus.o_pc_addr];
  assign bus.i_instruction = instr_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {SelA, SelB, op, WrAcc, WrRam, RdRam} straight from the opcode table.
  function automatic logic [6:0] exp_ctrl(input logic [4:0] opc);
    case (opc)
      5'd1:    return 7'b00_0_0_0_1_0;
      5'd2:    return 7'b00_0_0_1_0_1;
      5'd3:    return 7'b01_0_0_1_0_0;
      5'd4:    return 7'b10_0_0_1_0_1;
      5'd5:    return 7'b10_1_0_1_0_0;
      5'd6:    return 7'b10_0_1_1_0_1;
      5'd7:    return 7'b10_1_1_1_0_0;
      default: return 7'b0;
    endcase
  endfunction

  function automatic logic [6:0] obs_ctrl();
    return {bus.o_SelA, bus.o_SelB, bus.o_op, bus.o_WrAcc, bus.o_WrRam, bus.o_RdRam};
  endfunction

  task automatic chk_quiet(input string tag, input int pc);
    chk({tag, "_ctrl"}, {25'd0, obs_ctrl()}, 32'd0);
    chk({tag, "_operand"}, {21'd0, bus.o_operand}, 32'd0);
    chk({tag, "_pc"}, {21'd0, bus.o_pc_addr}, pc);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    start = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    m_pc = 0;
    m_count = 0;
    m_halted = 1'b0;
  endtask

  // Runs up to max_instr instructions from IDLE. If stop_at >= 0, reset is
  // asserted during the EXEC of that instruction index.
  task automatic run_prog(input string tag, input int max_instr, input int stop_at);
    logic [15:0] ins;
    start = 1'b1;
    tick();
    for (int k = 0; k < max_instr; k++) begin
      start = 1'($urandom_range(0, 1));
      chk_quiet({tag, "_fetch"}, m_pc);
      chk({tag, "_fetch_halt"}, {31'd0, halt}, 32'd0);
      chk({tag, "_fetch_cnt"}, {16'd0, icount}, m_count);
      tick();
      ins = mem[m_pc];
      chk({tag, "_exec_ctrl"}, {25'd0, obs_ctrl()}, {25'd0, exp_ctrl(ins[15:11])});
      chk({tag, "_exec_operand"}, {21'd0, bus.o_operand}, {21'd0, ins[10:0]});
      if (k == stop_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        m_pc = 0;
        m_count = 0;
        m_halted = 1'b0;
        return;
      end
      tick();
      if (m_count < 65535) m_count++;
      if (ins[15:11] == 5'd0) begin
        m_halted = 1'b1;
        break;
      end
      m_pc = (m_pc + 1) % 2048;
    end
    if (m_halted) begin
      for (int c = 0; c < 3; c++) begin
        start = 1'($urandom_range(0, 1));
        chk({tag, "_halt"}, {31'd0, halt}, 32'd1);
        chk_quiet({tag, "_halted"}, m_pc);
        chk({tag, "_halt_cnt"}, {16'd0, icount}, m_count);
        tick();
      end
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;

    // Reset and idle
    do_reset(2);
    for (int c = 0; c < 10; c++) begin
      chk_quiet("idle", 0);
      chk("idle_halt", {31'd0, halt}, 32'd0);
      chk("idle_cnt", {16'd0, icount}, 32'd0);
      tick();
    end

    // Directed program: LDI 5, ADDI 3, STO 16, HLT
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0810; mem[3] = 16'h0000;
    run_prog("basic", 10, -1);
    chk("basic_halted_pc", {21'd0, bus.o_pc_addr}, 32'd3);
    chk("basic_count", {16'd0, icount}, 32'd4);

    // Memory ops: LD 7, ADD 8, SUB 9, SUBI 2, HLT
    do_reset(1);
    mem[0] = 16'h1007; mem[1] = 16'h2008; mem[2] = 16'h3009; mem[3] = 16'h3802; mem[4] = 16'h0000;
    run_prog("memops", 10, -1);
    chk("memops_count", {16'd0, icount}, 32'd5);

    // Undefined opcode executes as NOP
    do_reset(1);
    mem[0] = 16'hF800; mem[1] = 16'h0000;
    run_prog("undef", 1, -1);
    chk("undef_pc", {21'd0, bus.o_pc_addr}, 32'd1);
    chk("undef_cnt", {16'd0, icount}, 32'd1);
    chk("undef_halt", {31'd0, halt}, 32'd0);

    // PC wrap over the full address space
    do_reset(1);
    for (int i = 0; i < 2048; i++) mem[i] = 16'h2801;
    run_prog("wrap", 2048, -1);
    chk("wrap_pc", {21'd0, bus.o_pc_addr}, 32'd0);
    chk("wrap_cnt", {16'd0, icount}, 32'd2048);
    chk("wrap_halt", {31'd0, halt}, 32'd0);

    // Reset during EXEC of instruction 2, then restart from address 0
    do_reset(1);
    for (int i = 0; i < 8; i++) mem[i] = 16'h1800 | 16'(i + 1);
    mem[8] = 16'h0000;
    run_prog("midrst", 8, 2);
    for (int c = 0; c < 4; c++) begin
      chk_quiet("midrst_idle", 0);
      chk("midrst_cnt", {16'd0, icount}, 32'd0);
      chk("midrst_halt", {31'd0, halt}, 32'd0);
      tick();
    end
    run_prog("restart", 20, -1);
    chk("restart_cnt", {16'd0, icount}, 32'd9);

    // Randomized programs over the full opcode space
    for (int p = 0; p < 6; p++) begin
      do_reset(1);
      for (int i = 0; i < 64; i++) begin
        logic [4:0] opc;
        opc = 5'($urandom_range(1, 31));
        if ($urandom_range(0, 15) == 0) opc = 5'd0;
        mem[i] = {opc, 11'($urandom)};
      end
      mem[63] = 16'h0000;
      run_prog("rand", 64, -1);
      chk("rand_halt", {31'd0, halt}, {31'd0, m_halted});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit for the BIP1 accumulator processor.
- Initiator side of the datapath control interface: fetches 16-bit instructions from program memory through its program counter, decodes the 5-bit opcode and drives the datapath controls SelA, SelB, WrAcc, op and operand.
- Also drives the data-memory read/write strobes.
- Sits beside the datapath inside the BIP1 top level; runs a small fetch/execute FSM with halt handling and an executed-instruction counter.

Parameters:
- NB_INSTR, 16, instruction word width
- NB_OPCODE, 5, opcode field width (instruction bits [15:11])
- NB_OPERAND, 11, operand field width (bits [10:0])
- NB_ADDR, 11, program-counter width
- NB_COUNT, 16, executed-instruction counter width

Ports:
- i_clk  in  1  clock, all state changes on the rising edge
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  leave IDLE and begin fetching at PC=0
- i_instruction  in  NB_INSTR  program-memory read data, valid one cycle after o_pc_addr is presented
- o_pc_addr  out  NB_ADDR  program-memory address (PC)
- o_SelA  out  2  accumulator source: 00 data memory, 01 immediate, 10 ALU
- o_SelB  out  1  ALU operand B: 0 data memory, 1 immediate
- o_WrAcc  out  1  accumulator write enable
- o_op  out  1  ALU op: 0 add, 1 subtract
- o_operand  out  NB_OPERAND  operand field, used as immediate or data address
- o_WrRam  out  1  data-memory write strobe
- o_RdRam  out  1  data-memory read strobe
- o_halt  out  1  processor halted
- o_instr_count  out  NB_COUNT  instructions executed, including HLT

Behaviour:
- Reset: synchronous, active-high, sampled on i_clk.
- Reset values: state IDLE, PC=0, o_instr_count=0, o_halt=0.
- All strobes 0 whenever state≠EXEC. o_SelA=00, o_SelB=0, o_op=0, o_operand=0 outside EXEC.
- States:
  - IDLE: wait for i_start=1, then go to FETCH.
  - FETCH: present PC; go to EXEC unconditionally.
  - EXEC: decode i_instruction combinationally; controls valid for exactly this cycle. Next state FETCH (PC+1), or HALT if opcode=HLT.
  - HALT: o_halt=1; PC frozen; left only by reset.
- Every instruction takes 2 cycles; the datapath commits on the rising edge that ends EXEC.
- Opcode decode (opcode → SelA/SelB/op/WrAcc/WrRam/RdRam):
  - HLT 00000 → all enables 0
  - STO 00001 → WrRam=1
  - LD 00010 → SelA=00, WrAcc=1, RdRam=1
  - LDI 00011 → SelA=01, WrAcc=1
  - ADD 00100 → SelA=10, SelB=0, op=0, WrAcc=1, RdRam=1
  - ADDI 00101 → SelA=10, SelB=1, op=0, WrAcc=1
  - SUB 00110 → SelA=10, SelB=0, op=1, WrAcc=1, RdRam=1
  - SUBI 00111 → SelA=10, SelB=1, op=1, WrAcc=1
- Undefined opcodes (01000–11111) execute as NOP: no enables, PC increments, counter increments.
- o_operand = i_instruction[10:0] in EXEC. Sign extension is the datapath's job.
- PC increments on the EXEC→FETCH edge. PC wraps 2^NB_ADDR−1 → 0 silently.
- o_instr_count increments on every EXEC cycle and saturates at all-ones.
- i_start is ignored outside IDLE.
- Reset asserted in any state, including mid-EXEC: the next edge goes to IDLE with reset values. The in-flight EXEC controls still act combinationally in that cycle; the top level holds the datapath in reset at the same time.
- o_halt is registered: it goes high on the edge leaving the HLT EXEC.

Decomposition:
- Shared package bip_pkg holds:
  - opcode localparams (OP_HLT…OP_SUBI)
  - SelA encodings (SELA_MEM, SELA_IMM, SELA_ALU)
  - FSM state encoding (ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT)
- One sub-module: bip_pc, a program counter with synchronous reset, increment enable and wrap.
- Decode stays as one combinational block inside bip_control.

Test Plan:
- Reset/idle: i_rst=1 for 2 cycles, then 0, i_start=0 for 10 cycles → o_pc_addr=0, all enables 0, o_halt=0, o_instr_count=0 throughout.
- Program {0:0x1805 LDI 5, 1:0x2803 ADDI 3, 2:0x0810 STO 16, 3:0x0000 HLT}, pulse i_start → each EXEC cycle shows the exact controls:
  - LDI: SelA=01, WrAcc=1, operand=5
  - ADDI: SelA=10, SelB=1, op=0, WrAcc=1, operand=3
  - STO: WrRam=1, operand=16
  - then o_halt=1, o_pc_addr stays 3, o_instr_count=4
- Memory ops {LD 7, ADD 8, SUB 9, SUBI 2} → RdRam=1 only in the EXEC cycles of LD/ADD/SUB; op=1 for SUB and SUBI; SelB=0 for SUB, 1 for SUBI.
- Undefined opcode 0xF800 at address 0 → no enables in EXEC, next fetch at PC=1, o_instr_count=1.
- PC wrap: fill all 2048 words with ADDI 1 → after 2048 EXECs o_pc_addr returns to 0, o_instr_count=2048, no halt.
- Reset mid-run: assert i_rst during the EXEC of instruction 2 → next edge PC=0, o_instr_count=0, state IDLE; a new i_start restarts fetching from address 0.
